uart_echo_tester: RTL and testbench
===================================

# uart_echo_tester

Synthesizable self-checking traffic generator for the UART echo path. It drives the parallel transmit side of the `UART` block, collects the echoed bytes from its receive side, and compares them against a queue of expected bytes. It reports pass/fail, error and byte counts, and timeout status. This generalises the single-byte 8'h7a echo check into a parametrised, multi-byte, pattern-selectable test with bounded outstanding traffic and a timeout. It is usable on-board or in simulation, with the CPU under test on the far side of the serial link.

## Interface
- `NumBytes`, 16: bytes per run. Range 1..65535.
- `MaxOutstanding`, 4: depth of the expected-byte FIFO, i.e. the maximum number of bytes sent but not yet echoed. Power of 2, at least 2.
- `TimeoutCycles`, 1_000_000: idle cycles in RUN before the run aborts.
- `Seed`, 8'h7A: first pattern byte.

- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- `Mode`  in  2  pattern: 0 = constant `Seed`; 1 = increment from `Seed`; 2 = LFSR from `Seed`; 3 = same as 1. Sampled on `Start`.
- `DataIn`  out  8  byte to the UART transmitter.
- `DataInValid`  out  1  transmit request.
- `DataInReady`  in  1  UART transmitter ready.
- `DataOut`  in  8  byte from the UART receiver.
- `DataOutValid`  in  1  received byte available.
- `DataOutReady`  out  1  byte accepted.
- `Busy`  out  1  high in RUN.
- `Done`  out  1  high in DONE.
- `Pass`  out  1  `Done` && ErrorCount==0 && !TimedOut.
- `TimedOut`  out  1  run aborted by timeout.
- `SentCount`, `RecvCount`, `ErrorCount`  out  16 each  run statistics.
- `FirstErrExpected`, `FirstErrGot`  out  8 each  operands of the first miscompare.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Entering RUN from IDLE or DONE on `Start`:
  - Clear counters, the first-error registers, `TimedOut`, the FIFO and the timeout counter.
  - Load the pattern register with `Seed`. In Mode 2 a `Seed` of 0 is replaced by 8'h01.
  - Latch `Mode`.
- `Start` during RUN is ignored.
- Transmit, RUN only:
  - `DataInValid`=1 whenever SentCount<`NumBytes` and FIFO not full. `DataIn` = pattern register.
  - Transfer occurs on a cycle with `DataInValid`&&`DataInReady`. On transfer:
    - Push `DataIn` into the FIFO.
    - SentCount++.
    - Advance the pattern: Mode 0 holds; Mode 1/3 adds +1 mod 256; Mode 2 computes next = (p>>1) ^ (p[0] ? 8'hB8 : 8'h00).
  - Once asserted, `DataInValid` and `DataIn` hold stable until transfer. The FIFO cannot fill without a transfer, so the request is never withdrawn in RUN.
- Receive:
  - `DataOutReady`=1 in all states.
  - Bytes accepted in IDLE or DONE are discarded and not counted.
  - In RUN, on `DataOutValid`&&`DataOutReady`:
    - RecvCount++.
    - FIFO non-empty: pop the head. If the head differs from `DataOut`, ErrorCount++; on the first error, capture the head into `FirstErrExpected` and `DataOut` into `FirstErrGot`.
    - FIFO empty: the byte is unexpected. ErrorCount++, no pop. On the first error, capture `FirstErrExpected`=8'h00 and `FirstErrGot`=`DataOut`.
- Push and pop in the same cycle leave the occupancy unchanged. The pop reads the pre-push head. Push is allowed when full only if a pop occurs in the same cycle; the transmit gate uses the registered full flag, so this never arises.
- Counters saturate at 16'hFFFF.
- RUN→DONE when RecvCount reaches `NumBytes` (the next RecvCount value equals `NumBytes`).
- Timeout:
  - The counter increments every RUN cycle and clears on any transmit transfer or receive acceptance.
  - When it reaches `TimeoutCycles`-1 without clearing: `TimedOut`←1 and RUN→DONE.
  - Completion and timeout in the same cycle: completion wins, `TimedOut` stays 0.
- DONE holds all statistics until `Start` or `Reset`.

## Timing
- Reset values, effective the cycle after `Reset` is sampled high:
  - State IDLE.
  - All outputs 0 except `DataOutReady`=1.
  - FIFO empty; pattern register `Seed`.
- Reset mid-run aborts immediately, with `DataInValid` low the next cycle.
- `Start` in cycle N gives `Busy`=1 and first `DataInValid`=1 in cycle N+1.
- Transmit-to-FIFO latency is 0 cycles; the byte is eligible to match a receive one cycle later.
- `Done` and `Pass` are registered and valid in the cycle after the final byte is accepted or the timeout fires. `Busy` and `Done` are never both high.

## Test plan
- Mode 1, `Seed` 8'h7A, `NumBytes` 4, behavioural echo with 1-cycle return → receives 7A 7B 7C 7D; Done=1, Pass=1, SentCount=RecvCount=4, ErrorCount=0.
- Same setup, echo XORs the 3rd byte with 8'h01 → ErrorCount=1, FirstErrExpected=8'h7C, FirstErrGot=8'h7D, Pass=0.
- Echo drops the 4th byte, `TimeoutCycles` 100 → TimedOut=1 and Done exactly 100 cycles after the 3rd receive; RecvCount=3, Pass=0.
- `MaxOutstanding` 2, echo withheld, `DataInReady` toggling → SentCount stalls at 2; `DataIn` and `DataInValid` stable while Ready is low; transmission resumes one cycle after the first echo is accepted.
- Mode 2, `Seed` 8'h01 → sent bytes 01, B8, 5C, 2E; also Mode 2 with `Seed` 0 sends 01 first. An extra unsolicited byte 8'h55 with the FIFO empty gives ErrorCount=1, FirstErrGot=8'h55.
- `Reset` for 1 cycle mid-run (SentCount=2) → all outputs reset next cycle; a subsequent `Start` with clean echo gives Pass=1 with fresh counts.

Source files
------------

// File: rtl/uart_echo_tester.sv
// Echo-path traffic generator: drives a byte pattern into the UART transmitter,
// matches echoed bytes against an expected-byte FIFO and reports run statistics.
module uart_echo_tester #(
    parameter int unsigned NumBytes       = 16,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1_000_000,
    parameter logic [7:0]  Seed           = 8'h7A
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Mode,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic        TimedOut,
    output logic [15:0] SentCount,
    output logic [15:0] RecvCount,
    output logic [15:0] ErrorCount,
    output logic [7:0]  FirstErrExpected,
    output logic [7:0]  FirstErrGot
);

    localparam int unsigned AddrW  = $clog2(MaxOutstanding);
    localparam int unsigned CntW   = AddrW + 1;
    localparam int unsigned TimerW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } StateT;

    StateT             state;
    logic [7:0]        pattern;
    logic [1:0]        modeQ;
    logic [7:0]        fifoMem [MaxOutstanding];
    logic [AddrW-1:0]  wrPtr;
    logic [AddrW-1:0]  rdPtr;
    logic [CntW-1:0]   count;
    logic [TimerW-1:0] timer;
    logic [TimerW-1:0] timerNext;
    logic [15:0]       recvNext;

    logic fifoFull;
    logic fifoEmpty;
    logic txFire;
    logic rxFire;
    logic push;
    logic pop;
    logic headMiss;
    logic rxError;
    logic firstError;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] nextPattern(input logic [7:0] p, input logic [1:0] m);
        case (m)
            2'd0:    return p;
            2'd2:    return (p >> 1) ^ (p[0] ? 8'hB8 : 8'h00);
            default: return p + 8'd1;
        endcase
    endfunction

    // Status decode from registered state; the transmit gate only sees the registered full flag
    assign fifoFull     = (count == CntW'(MaxOutstanding));
    assign fifoEmpty    = (count == '0);
    assign DataInValid  = (state == StRun) && (SentCount < 16'(NumBytes)) && !fifoFull;
    assign DataIn       = DataInValid ? pattern : 8'h00;
    assign DataOutReady = 1'b1;
    assign Busy         = (state == StRun);
    assign Done         = (state == StDone);
    assign Pass         = Done && (ErrorCount == 16'h0000) && !TimedOut;

    assign txFire     = DataInValid && DataInReady;
    assign rxFire     = (state == StRun) && DataOutValid && DataOutReady;
    assign push       = txFire;
    assign pop        = rxFire && !fifoEmpty;
    assign headMiss   = (fifoMem[rdPtr] != DataOut);
    assign rxError    = rxFire && (fifoEmpty || headMiss);
    assign firstError = rxError && (ErrorCount == 16'h0000);
    assign recvNext   = satInc(RecvCount);
    assign timerNext  = timer + TimerW'(1);

    always_ff @(posedge Clock) begin
        if (push) begin
            fifoMem[wrPtr] <= pattern;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= StIdle;
            pattern          <= Seed;
            modeQ            <= 2'd0;
            wrPtr            <= '0;
            rdPtr            <= '0;
            count            <= '0;
            timer            <= '0;
            SentCount        <= 16'h0000;
            RecvCount        <= 16'h0000;
            ErrorCount       <= 16'h0000;
            FirstErrExpected <= 8'h00;
            FirstErrGot      <= 8'h00;
            TimedOut         <= 1'b0;
        end else begin
            case (state)
                StRun: begin
                    if (push) begin
                        wrPtr     <= wrPtr + AddrW'(1);
                        SentCount <= satInc(SentCount);
                        pattern   <= nextPattern(pattern, modeQ);
                    end
                    if (pop) begin
                        rdPtr <= rdPtr + AddrW'(1);
                    end
                    if (push && !pop) begin
                        count <= count + CntW'(1);
                    end else if (!push && pop) begin
                        count <= count - CntW'(1);
                    end
                    if (rxFire) begin
                        RecvCount <= recvNext;
                    end
                    if (rxError) begin
                        ErrorCount <= satInc(ErrorCount);
                    end
                    if (firstError) begin
                        FirstErrExpected <= fifoEmpty ? 8'h00 : fifoMem[rdPtr];
                        FirstErrGot      <= DataOut;
                    end
                    if (txFire || rxFire) begin
                        timer <= '0;
                    end else begin
                        timer <= timerNext;
                    end
                    // Completion takes priority over a coincident timeout
                    if (rxFire && (recvNext == 16'(NumBytes))) begin
                        state <= StDone;
                    end else if (!txFire && !rxFire && (timerNext == TimerW'(TimeoutCycles - 1))) begin
                        TimedOut <= 1'b1;
                        state    <= StDone;
                    end
                end
                default: begin
                    if (Start) begin
                        state            <= StRun;
                        pattern          <= ((Mode == 2'd2) && (Seed == 8'h00)) ? 8'h01 : Seed;
                        modeQ            <= Mode;
                        wrPtr            <= '0;
                        rdPtr            <= '0;
                        count            <= '0;
                        timer            <= '0;
                        SentCount        <= 16'h0000;
                        RecvCount        <= 16'h0000;
                        ErrorCount       <= 16'h0000;
                        FirstErrExpected <= 8'h00;
                        FirstErrGot      <= 8'h00;
                        TimedOut         <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester with a behavioural echo model and
// queue-based scoreboard of transmitted and echoed bytes.
module tb_uart_echo_tester;

    localparam int unsigned NumBytes = 4;
    localparam logic [7:0]  Seed     = 8'h7A;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Mode;
    logic        DataInReady;
    logic [7:0]  DataOut = 8'h00;
    logic        DataOutValid = 1'b0;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataOutReady;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic        TimedOut;
    logic [15:0] SentCount;
    logic [15:0] RecvCount;
    logic [15:0] ErrorCount;
    logic [7:0]  FirstErrExpected;
    logic [7:0]  FirstErrGot;

    logic        startZ;
    logic [7:0]  dataInZ;
    logic        dataInValidZ;
    logic        dataOutReadyZ;
    logic        busyZ;
    logic        doneZ;
    logic        passZ;
    logic        timedOutZ;
    logic [15:0] sentCountZ;
    logic [15:0] recvCountZ;
    logic [15:0] errorCountZ;
    logic [7:0]  firstErrExpectedZ;
    logic [7:0]  firstErrGotZ;

    int checks = 0;
    int errors = 0;

    logic [7:0] echoQ[$];
    logic [7:0] txLog[$];
    logic [7:0] rxLog[$];
    logic [7:0] txLogZ[$];
    logic [7:0] expTx[$];
    logic [7:0] expRx[$];
    int         txCyc[$];
    int         rxCyc[$];
    int         cyc = 0;
    int         echoIdx = 0;
    int         xorIdx = 0;
    int         dropIdx = 0;
    bit         echoHold = 1'b0;
    int         injectSeq = 0;
    int         injectAck = 0;
    logic [7:0] injectByte = 8'h00;
    logic [7:0] echoByte;

    uart_echo_tester #(
        .NumBytes(NumBytes), .MaxOutstanding(2), .TimeoutCycles(100), .Seed(Seed)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
        .Busy(Busy), .Done(Done), .Pass(Pass), .TimedOut(TimedOut),
        .SentCount(SentCount), .RecvCount(RecvCount), .ErrorCount(ErrorCount),
        .FirstErrExpected(FirstErrExpected), .FirstErrGot(FirstErrGot)
    );

    // LFSR instance with a zero seed and no echo: it sends one window and times out
    uart_echo_tester #(
        .NumBytes(4), .MaxOutstanding(4), .TimeoutCycles(100), .Seed(8'h00)
    ) dutZ (
        .Clock(Clock), .Reset(Reset), .Start(startZ), .Mode(2'd2),
        .DataIn(dataInZ), .DataInValid(dataInValidZ), .DataInReady(1'b1),
        .DataOut(8'h00), .DataOutValid(1'b0), .DataOutReady(dataOutReadyZ),
        .Busy(busyZ), .Done(doneZ), .Pass(passZ), .TimedOut(timedOutZ),
        .SentCount(sentCountZ), .RecvCount(recvCountZ), .ErrorCount(errorCountZ),
        .FirstErrExpected(firstErrExpectedZ), .FirstErrGot(firstErrGotZ)
    );

    always #5 Clock = ~Clock;

    // Echo model: logs transfers, returns each sent byte one cycle later unless held
    always @(posedge Clock) begin
        if (Reset || Start) begin
            echoQ.delete();
            txLog.delete();
            rxLog.delete();
            txCyc.delete();
            rxCyc.delete();
            echoIdx = 0;
            if (Start && !Reset && (injectSeq != injectAck)) begin
                echoQ.push_back(injectByte);
                injectAck = injectSeq;
            end
        end else begin
            if (DataInValid && DataInReady) begin
                echoIdx = echoIdx + 1;
                echoByte = DataIn;
                txLog.push_back(echoByte);
                txCyc.push_back(cyc);
                if (echoIdx == xorIdx) echoByte = echoByte ^ 8'h01;
                if (echoIdx != dropIdx) echoQ.push_back(echoByte);
            end
            if (DataOutValid && DataOutReady && Busy) begin
                rxLog.push_back(DataOut);
                rxCyc.push_back(cyc);
            end
        end
        if (dataInValidZ) txLogZ.push_back(dataInZ);
        cyc = cyc + 1;
        #1;
        if (!echoHold && (echoQ.size() > 0)) begin
            DataOut      = echoQ.pop_front();
            DataOutValid = 1'b1;
        end else begin
            DataOutValid = 1'b0;
        end
    end

    function automatic logic [7:0] lfsr(input logic [7:0] p);
        return {1'b0, p[7:1]} ^ (p[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadExp(input logic [1:0] m, input logic [7:0] seed, input int xi, input int di);
        logic [7:0] p;
        expTx.delete();
        expRx.delete();
        p = ((m == 2'd2) && (seed == 8'h00)) ? 8'h01 : seed;
        for (int i = 1; i <= int'(NumBytes); i++) begin
            expTx.push_back(p);
            if (i != di) expRx.push_back((i == xi) ? (p ^ 8'h01) : p);
            if (m == 2'd2) p = lfsr(p);
            else if (m != 2'd0) p = p + 8'd1;
        end
    endtask

    task automatic checkStreams(input string tag, input int nRx);
        int nTx;
        nTx = expTx.size();
        check({tag, "_txn"}, 32'(txLog.size()), 32'(nTx));
        for (int i = 0; i < nTx && i < txLog.size(); i++)
            check({tag, "_tx"}, 32'(txLog[i]), 32'(expTx.pop_front()));
        check({tag, "_rxn"}, 32'(rxLog.size()), 32'(nRx));
        for (int i = 0; i < nRx && i < rxLog.size(); i++)
            check({tag, "_rx"}, 32'(rxLog[i]), 32'(expRx.pop_front()));
    endtask

    task automatic pulseStart(input logic [1:0] m);
        Mode  = m;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic waitDone(input string tag, output int at);
        int n;
        n = 0;
        while ((Done !== 1'b1) && (n < 400)) begin
            @(negedge Clock);
            n++;
        end
        check(tag, 32'(Done), 32'(1));
        at = cyc;
    endtask

    initial begin
        int doneAt;
        int rxAt;
        int txAt;
        int n;
        logic pv;
        logic pr;
        logic [7:0] pd;
        logic [7:0] pz;

        Reset       = 1'b1;
        Start       = 1'b0;
        Mode        = 2'd0;
        DataInReady = 1'b1;
        startZ      = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_done", 32'(Done), 32'(0));
        check("rst_valid", 32'(DataInValid), 32'(0));
        check("rst_data", 32'(DataIn), 32'(0));
        check("rst_ready", 32'(DataOutReady), 32'(1));
        check("rst_sent", 32'(SentCount), 32'(0));
        check("rst_pass", 32'(Pass), 32'(0));

        startZ = 1'b1;
        @(negedge Clock);
        startZ = 1'b0;

        // Clean incrementing run
        loadExp(2'd1, Seed, 0, 0);
        pulseStart(2'd1);
        check("t1_busy", 32'(Busy), 32'(1));
        check("t1_first_valid", 32'(DataInValid), 32'(1));
        check("t1_first_data", 32'(DataIn), 32'h7A);
        waitDone("t1_done", doneAt);
        check("t1_pass", 32'(Pass), 32'(1));
        check("t1_busy_off", 32'(Busy), 32'(0));
        check("t1_sent", 32'(SentCount), 32'(4));
        check("t1_recv", 32'(RecvCount), 32'(4));
        check("t1_err", 32'(ErrorCount), 32'(0));
        checkStreams("t1", 4);

        // Third echo corrupted
        xorIdx = 3;
        loadExp(2'd1, Seed, 3, 0);
        pulseStart(2'd1);
        waitDone("t2_done", doneAt);
        check("t2_err", 32'(ErrorCount), 32'(1));
        check("t2_first_exp", 32'(FirstErrExpected), 32'h7C);
        check("t2_first_got", 32'(FirstErrGot), 32'h7D);
        check("t2_pass", 32'(Pass), 32'(0));
        checkStreams("t2", 4);
        xorIdx = 0;

        // Fourth echo dropped -> timeout
        dropIdx = 4;
        loadExp(2'd1, Seed, 0, 4);
        pulseStart(2'd1);
        waitDone("t3_done", doneAt);
        rxAt = (rxCyc.size() >= 3) ? rxCyc[2] : -1000;
        check("t3_timeout_lat", 32'(doneAt - rxAt), 32'(100));
        check("t3_timedout", 32'(TimedOut), 32'(1));
        check("t3_recv", 32'(RecvCount), 32'(3));
        check("t3_pass", 32'(Pass), 32'(0));
        checkStreams("t3", 3);
        dropIdx = 0;

        // Outstanding window with echo withheld and a toggling ready
        echoHold    = 1'b1;
        DataInReady = 1'b0;
        loadExp(2'd1, Seed, 0, 0);
        pulseStart(2'd1);
        for (int i = 0; i < 14; i++) begin
            pv = DataInValid;
            pd = DataIn;
            DataInReady = (i % 2 == 1);
            pr = DataInReady;
            @(negedge Clock);
            if (pv && !pr) begin
                check("t4_hold_valid", 32'(DataInValid), 32'(1));
                check("t4_hold_data", 32'(DataIn), 32'(pd));
            end
        end
        check("t4_stall_sent", 32'(SentCount), 32'(2));
        check("t4_stall_valid", 32'(DataInValid), 32'(0));
        DataInReady = 1'b1;
        echoHold    = 1'b0;
        waitDone("t4_done", doneAt);
        rxAt = (rxCyc.size() >= 1) ? rxCyc[0] : -1000;
        txAt = (txCyc.size() >= 3) ? txCyc[2] : -1000;
        check("t4_resume_lat", 32'(txAt - rxAt), 32'(1));
        check("t4_pass", 32'(Pass), 32'(1));
        checkStreams("t4", 4);

        // LFSR run with an unsolicited byte while the FIFO is empty
        injectByte = 8'h55;
        injectSeq  = injectSeq + 1;
        loadExp(2'd2, Seed, 0, 0);
        expRx.push_front(8'h55);
        pulseStart(2'd2);
        waitDone("t5_done", doneAt);
        check("t5_err", 32'(ErrorCount), 32'(1));
        check("t5_first_exp", 32'(FirstErrExpected), 32'h00);
        check("t5_first_got", 32'(FirstErrGot), 32'h55);
        check("t5_recv", 32'(RecvCount), 32'(4));
        check("t5_pass", 32'(Pass), 32'(0));
        checkStreams("t5", 4);

        // Zero-seed LFSR instance
        check("tz_txn", 32'(txLogZ.size()), 32'(4));
        pz = 8'h01;
        for (int i = 0; i < 4 && i < txLogZ.size(); i++) begin
            check("tz_tx", 32'(txLogZ[i]), 32'(pz));
            pz = lfsr(pz);
        end
        check("tz_timedout", 32'(timedOutZ), 32'(1));
        check("tz_done", 32'(doneZ), 32'(1));
        check("tz_sent", 32'(sentCountZ), 32'(4));

        // Reset mid-run, then a fresh clean run
        echoHold = 1'b1;
        pulseStart(2'd1);
        n = 0;
        while ((SentCount !== 16'd2) && (n < 20)) begin
            @(negedge Clock);
            n++;
        end
        check("t6_pre_sent", 32'(SentCount), 32'(2));
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("t6_busy", 32'(Busy), 32'(0));
        check("t6_valid", 32'(DataInValid), 32'(0));
        check("t6_data", 32'(DataIn), 32'(0));
        check("t6_sent", 32'(SentCount), 32'(0));
        check("t6_recv", 32'(RecvCount), 32'(0));
        check("t6_done", 32'(Done), 32'(0));
        check("t6_ready", 32'(DataOutReady), 32'(1));
        echoHold = 1'b0;
        loadExp(2'd1, Seed, 0, 0);
        pulseStart(2'd1);
        waitDone("t6_done2", doneAt);
        check("t6_pass", 32'(Pass), 32'(1));
        check("t6_sent2", 32'(SentCount), 32'(4));
        check("t6_recv2", 32'(RecvCount), 32'(4));
        checkStreams("t6", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
